esm_issue_queue: RTL and testbench

//  Instruction issue front-end for the ESM execute stage. Buffers incoming instructions in a FIFO.

---
 rtl/esm_issue_queue_if.sv | 29 ++
 rtl/esm_issue_queue.sv | 124 ++++++++++++
 tb/tb_esm_issue_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/esm_issue_queue_if.sv
// Producer-side and ESM-side signals of the issue queue, bundled so the queue
// and its environment share one definition.
interface esm_issue_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          flush;
  logic          stall;
  logic          issue_valid;
  logic [31:0]   issue_instr;
  logic          issue_alusrc;
  logic          issue_regwrite;
  logic          illegal;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_instr, flush, stall,
    input  in_ready, issue_valid, issue_instr, issue_alusrc, issue_regwrite, illegal, count
  );

  modport slave (
    input  in_valid, in_instr, flush, stall,
    output in_ready, issue_valid, issue_instr, issue_alusrc, issue_regwrite, illegal, count
  );
endinterface

// File: rtl/esm_issue_queue.sv
// Issue front-end for the ESM execute stage: instruction FIFO, opcode decode and a
// registered issue slot that inserts bubbles when empty and holds on stall.
module esm_issue_queue #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0
) (
  input logic              clk,
  input logic              rst_n,
  esm_issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          issue_valid_q, issue_valid_d;
  logic [31:0]   issue_instr_q, issue_instr_d;
  logic          issue_alusrc_q, issue_alusrc_d;
  logic          issue_regwrite_q, issue_regwrite_d;
  logic          illegal_q, illegal_d;

  logic          full, empty, push, pop;
  logic [31:0]   head;
  logic          dec_valid, dec_as, dec_rw, dec_ill;
  logic [31:0]   dec_instr;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !bus.stall && !empty;
  assign head  = mem_q[rd_ptr_q];

  // The all-zero word is a deliberate bubble; any other unknown opcode is flagged.
  always_comb begin
    dec_valid = 1'b0;
    dec_as    = 1'b0;
    dec_rw    = 1'b0;
    dec_ill   = 1'b0;
    dec_instr = NOP_INSTR;
    case (head[6:0])
      7'b0000011: begin dec_valid = 1'b1; dec_as = 1'b1; dec_rw = 1'b1; dec_instr = head; end
      7'b0010011: begin dec_valid = 1'b1; dec_as = 1'b1; dec_rw = 1'b1; dec_instr = head; end
      7'b0110011: begin dec_valid = 1'b1; dec_as = 1'b0; dec_rw = 1'b1; dec_instr = head; end
      7'b0100011: begin dec_valid = 1'b1; dec_as = 1'b1; dec_rw = 1'b0; dec_instr = head; end
      7'b1010011: begin dec_valid = 1'b1; dec_as = 1'b0; dec_rw = 1'b0; dec_instr = head; end
      default:    dec_ill = (head != 32'h0);
    endcase
  end

  always_comb begin
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    issue_valid_d    = issue_valid_q;
    issue_instr_d    = issue_instr_q;
    issue_alusrc_d   = issue_alusrc_q;
    issue_regwrite_d = issue_regwrite_q;
    illegal_d        = illegal_q;
    if (bus.flush) begin
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      count_d          = '0;
      issue_valid_d    = 1'b0;
      issue_instr_d    = NOP_INSTR;
      issue_alusrc_d   = 1'b0;
      issue_regwrite_d = 1'b0;
      illegal_d        = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
      if (!bus.stall) begin
        if (empty) begin
          issue_valid_d    = 1'b0;
          issue_instr_d    = NOP_INSTR;
          issue_alusrc_d   = 1'b0;
          issue_regwrite_d = 1'b0;
          illegal_d        = 1'b0;
        end else begin
          issue_valid_d    = dec_valid;
          issue_instr_d    = dec_instr;
          issue_alusrc_d   = dec_as;
          issue_regwrite_d = dec_rw;
          illegal_d        = dec_ill;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      issue_valid_q    <= 1'b0;
      issue_instr_q    <= NOP_INSTR;
      issue_alusrc_q   <= 1'b0;
      issue_regwrite_q <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      if (push && !bus.flush) mem_q[wr_ptr_q] <= bus.in_instr;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      issue_valid_q    <= issue_valid_d;
      issue_instr_q    <= issue_instr_d;
      issue_alusrc_q   <= issue_alusrc_d;
      issue_regwrite_q <= issue_regwrite_d;
      illegal_q        <= illegal_d;
    end
  end

  assign bus.in_ready       = !full;
  assign bus.count          = count_q;
  assign bus.issue_valid    = issue_valid_q;
  assign bus.issue_instr    = issue_instr_q;
  assign bus.issue_alusrc   = issue_alusrc_q;
  assign bus.issue_regwrite = issue_regwrite_q;
  assign bus.illegal        = illegal_q;
endmodule

// File: tb/tb_esm_issue_queue.sv
// Directed bench for esm_issue_queue: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_esm_issue_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  esm_issue_queue_if #(.DEPTH(8)) bus ();

  esm_issue_queue #(.DEPTH(8), .NOP_INSTR(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic v, input logic [31:0] ins,
                           input logic as, input logic rw, input logic ill);
    chk({tag, ".valid"}, 32'(bus.issue_valid), 32'(v));
    chk({tag, ".instr"}, bus.issue_instr, ins);
    chk({tag, ".alusrc"}, 32'(bus.issue_alusrc), 32'(as));
    chk({tag, ".regwrite"}, 32'(bus.issue_regwrite), 32'(rw));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
  endtask

  task automatic chk_cnt(input string tag, input int c);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(c != 8));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wimm(input int i);
    return {12'(i + 1), 20'h00013};
  endfunction

  function automatic logic [31:0] wop(input int i);
    return 32'h00000033 | (32'(i) << 15);
  endfunction

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;

    #2;
    chk_cnt("rst", 0);
    chk_issue("rst", 0, 32'h0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // 1: single push, one-cycle latency, then bubble
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A00393;
    tick();
    bus.in_valid = 1'b0;
    chk_cnt("t1.push", 1);
    chk_issue("t1.push", 0, 32'h0, 0, 0, 0);
    tick();
    chk_cnt("t1.iss", 0);
    chk_issue("t1.iss", 1, 32'h00A00393, 1, 1, 0);
    tick();
    chk_issue("t1.bub", 0, 32'h0, 0, 0, 0);

    // 2: back-to-back stream
    bus.in_valid = 1'b1; bus.in_instr = 32'h008384B3;
    tick();
    chk_cnt("t2.e1", 1);
    bus.in_instr = 32'h40740533;
    tick();
    chk_cnt("t2.e2", 1);
    chk_issue("t2.e2", 1, 32'h008384B3, 0, 1, 0);
    bus.in_instr = 32'h0010A253;
    tick();
    chk_cnt("t2.e3", 1);
    chk_issue("t2.e3", 1, 32'h40740533, 0, 1, 0);
    bus.in_valid = 1'b0;
    tick();
    chk_cnt("t2.e4", 0);
    chk_issue("t2.e4", 1, 32'h0010A253, 0, 0, 0);

    // 3: fill under stall, refused 9th push, frozen outputs, drain across wrap
    bus.stall = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_instr = wimm(i);
      tick();
      chk_cnt("t3.fill", i + 1);
    end
    bus.in_instr = 32'hDEAD0013;
    tick();
    chk_cnt("t3.ninth", 8);
    chk_issue("t3.frozen", 1, 32'h0010A253, 0, 0, 0);
    bus.in_valid = 1'b0; bus.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_cnt("t3.drain", 7 - i);
      chk_issue("t3.drain", 1, wimm(i), 1, 1, 0);
    end
    tick();
    chk_issue("t3.bub", 0, 32'h0, 0, 0, 0);

    // 4: full with concurrent pop refuses the push; accepted next cycle
    bus.stall = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_instr = wop(i);
      tick();
    end
    chk_cnt("t4.full", 8);
    bus.stall = 1'b0; bus.in_instr = 32'h00100093;
    tick();
    chk_cnt("t4.refuse", 7);
    chk_issue("t4.refuse", 1, wop(0), 0, 1, 0);
    tick();
    bus.in_valid = 1'b0;
    chk_cnt("t4.accept", 7);
    chk_issue("t4.accept", 1, wop(1), 0, 1, 0);
    for (int i = 2; i < 8; i++) begin
      tick();
      chk_cnt("t4.drain", 8 - i);
      chk_issue("t4.drain", 1, wop(i), 0, 1, 0);
    end
    tick();
    chk_cnt("t4.last", 0);
    chk_issue("t4.last", 1, 32'h00100093, 1, 1, 0);

    // 5: illegal opcode, then a legal load, then an all-zero bubble word
    bus.in_valid = 1'b1; bus.in_instr = 32'hFFFFFFFF;
    tick();
    bus.in_instr = 32'h0000A103;
    tick();
    chk_cnt("t5.ill", 1);
    chk_issue("t5.ill", 0, 32'h0, 0, 0, 1);
    bus.in_instr = 32'h0;
    tick();
    bus.in_valid = 1'b0;
    chk_issue("t5.load", 1, 32'h0000A103, 1, 1, 0);
    tick();
    chk_cnt("t5.zero", 0);
    chk_issue("t5.zero", 0, 32'h0, 0, 0, 0);

    // 6: flush beats stall and push; async reset mid-stream
    bus.stall = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = wimm(i);
      tick();
    end
    chk_cnt("t6.q3", 3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.stall = 1'b0;
    chk_cnt("t6.flush", 0);
    chk_issue("t6.flush", 0, 32'h0, 0, 0, 0);
    bus.in_instr = 32'h0000A103;
    tick();
    bus.in_valid = 1'b0;
    chk_cnt("t6.push", 1);
    tick();
    chk_issue("t6.iss", 1, 32'h0000A103, 1, 1, 0);
    bus.in_valid = 1'b1; bus.in_instr = 32'h00A00393;
    tick();
    bus.in_valid = 1'b0;
    chk_cnt("t6.pre_rst", 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_cnt("t6.rst", 0);
    chk_issue("t6.rst", 0, 32'h0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt("t6.after", 0);
    chk_issue("t6.after", 0, 32'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
